// File: rtl/hs_pkg.sv
// Shared definitions for the send/ack four-phase handshake (sender and receiver).
// Contents: FSM state type and encodings, default word width, count-width helper.
package hs_pkg;

  // Handshake FSM state, kept as plain 1-bit constants for legacy compatibility
  typedef logic [0:0] hs_state_t;
  localparam hs_state_t HS_IDLE = 1'b0;
  localparam hs_state_t HS_ACK  = 1'b1;

  localparam int unsigned HS_WORD_W = 8;

  // Width of a counter that must hold values 0..w inclusive
  function automatic int unsigned hs_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned HS_CNT_W = hs_cnt_w(HS_WORD_W);

endpackage : hs_pkg

// File: rtl/hs_word_rx_sync_ff.sv
// Single-bit multi-flop synchroniser for a signal that is asynchronous to clk.
// Ports: clk, rst (async active-low), d (async input), q (synchronised output).
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift chain; the last flop is the synchronised output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule : sync_ff

// File: rtl/hs_word_rx.sv
// Receiving end of the 1-bit send/ack four-phase handshake. Synchronises 'send',
// samples 'data' once per handshake, returns 'ack', and assembles WORD_W-bit words
// for a valid/ready consumer. Backpressure is applied by withholding 'ack'.
// Ports:
//   clk, rst (async active-low)
//   send, data  : handshake request and serial bit from the foreign sender
//   ack         : handshake acknowledge (registered)
//   clr         : discard partial word (ignored while a complete word is waiting)
//   word_data, word_valid, word_ready : assembled-word output port
//   bit_cnt     : bits currently held in the shift register
module hs_word_rx
  import hs_pkg::*;
#(
  parameter int unsigned WORD_W      = HS_WORD_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         send,
  input  logic                         data,
  output logic                         ack,
  input  logic                         clr,
  output logic [WORD_W-1:0]            word_data,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [$clog2(WORD_W+1)-1:0]  bit_cnt
);

  localparam int unsigned      CNT_W    = hs_cnt_w(WORD_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic              s_send;
  hs_state_t         state;
  hs_state_t         state_nxt;
  logic              ack_nxt;
  logic              accept_c;
  logic              shift_full_c;
  logic              room_c;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_nxt;
  logic [WORD_W-1:0] shifted_c;
  logic [WORD_W-1:0] word_nxt;
  logic              valid_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // 'send' crosses into the clk domain here; nothing below looks at raw 'send'
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_send (
    .clk (clk),
    .rst (rst),
    .d   (send),
    .q   (s_send)
  );

  // A complete word parked in the shift register stalls further bit acceptance
  assign shift_full_c = (bit_cnt == CNT_FULL);
  // Output holding register can take a word this cycle
  assign room_c       = !word_valid || word_ready;

  // State and ack registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HS_IDLE;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= ack_nxt;
    end
  end

  // Next-state: one bit per send high phase, held off while stalled
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      HS_IDLE: begin
        if (s_send && !shift_full_c) begin
          accept_c  = 1'b1;
          state_nxt = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!s_send) state_nxt = HS_IDLE;
      end
      default: state_nxt = HS_IDLE;
    endcase
    ack_nxt = (state_nxt == HS_ACK);
  end

  // First received bit ends up at the MSB (shift left) or LSB (shift right)
  assign shifted_c = MSB_FIRST ? {shreg[WORD_W-2:0], data} : {data, shreg[WORD_W-1:1]};

  // Shift register, bit count and output holding register next values
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    word_nxt  = word_data;
    valid_nxt = word_valid;

    if (word_valid && word_ready) valid_nxt = 1'b0;

    if (shift_full_c) begin
      // Parked word moves across once the holding register frees up; clr is ignored
      if (room_c) begin
        word_nxt  = shreg;
        valid_nxt = 1'b1;
        cnt_nxt   = '0;
      end
    end else if (accept_c) begin
      shreg_nxt = shifted_c;
      if (clr) begin
        // Old bits are dropped; the new bit starts a fresh word
        cnt_nxt = CNT_W'(1);
      end else if (bit_cnt == CNT_LAST) begin
        if (room_c) begin
          word_nxt  = shifted_c;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = CNT_FULL;
        end
      end else begin
        cnt_nxt = bit_cnt + CNT_W'(1);
      end
    end else if (clr) begin
      cnt_nxt = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      shreg      <= shreg_nxt;
      bit_cnt    <= cnt_nxt;
      word_data  <= word_nxt;
      word_valid <= valid_nxt;
    end
  end

endmodule : hs_word_rx

// File: tb/tb_hs_word_rx.sv
// Directed self-checking bench for hs_word_rx: an 8-bit MSB-first instance and a
// 4-bit LSB-first instance, each driven by a behavioural four-phase sender.
module tb_hs_word_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: WORD_W=8, MSB_FIRST=1
  logic       send_a, data_a, clr_a, ready_a, ack_a, wv_a;
  logic [7:0] wd_a;
  logic [3:0] bc_a;

  // Instance B: WORD_W=4, MSB_FIRST=0
  logic       send_b, data_b, clr_b, ready_b, ack_b, wv_b;
  logic [3:0] wd_b;
  logic [2:0] bc_b;

  hs_word_rx #(.WORD_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .send(send_a), .data(data_a), .ack(ack_a), .clr(clr_a),
    .word_data(wd_a), .word_valid(wv_a), .word_ready(ready_a), .bit_cnt(bc_a)
  );

  hs_word_rx #(.WORD_W(4), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .send(send_b), .data(data_b), .ack(ack_b), .clr(clr_b),
    .word_data(wd_b), .word_valid(wv_b), .word_ready(ready_b), .bit_cnt(bc_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Consumer-side monitors, sampled on the falling edge
  logic [7:0] last_a = '0;
  logic [3:0] last_b = '0;
  int words_a = 0, words_b = 0, pulses_a = 0, vcyc_a = 0;
  logic ack_a_d = 1'b0;

  always @(negedge clk) begin
    if (wv_a && ready_a) begin last_a = wd_a; words_a++; end
    if (wv_b && ready_b) begin last_b = wd_b; words_b++; end
    if (wv_a) vcyc_a++;
    if (ack_a && !ack_a_d) pulses_a++;
    ack_a_d = ack_a;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n clocks and settle just after the rising edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? ack_a : ack_b;
  endfunction

  task automatic drive(input int sel, input logic s, input logic d);
    if (sel == 0) begin send_a = s; data_a = d; end
    else          begin send_b = s; data_b = d; end
  endtask

  task automatic wait_ack(input int sel, input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (get_ack(sel) == lvl) begin ok = 1'b1; return; end
    end
  endtask

  // Complete four-phase handshake for one bit
  task automatic hs_bit(input int sel, input logic b);
    bit ok;
    drive(sel, 1'b1, b);
    wait_ack(sel, 1'b1, 30, ok);
    if (!ok) check("ack_rise_timeout", 32'd0, 32'd1);
    drive(sel, 1'b0, b);
    wait_ack(sel, 1'b0, 30, ok);
    if (!ok) check("ack_fall_timeout", 32'd1, 32'd0);
  endtask

  task automatic hs_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) hs_bit(0, v[i]);
  endtask

  initial begin
    bit ok;
    int p0;
    logic [7:0] w33;
    rst = 1'b0;
    send_a = 0; data_a = 0; clr_a = 0; ready_a = 0;
    send_b = 0; data_b = 0; clr_b = 0; ready_b = 0;
    cyc(3);
    check("rst_ack", ack_a, 0);
    check("rst_valid", wv_a, 0);
    check("rst_data", wd_a, 0);
    check("rst_cnt", bc_a, 0);
    rst = 1'b1;
    cyc(2);

    // 0xA5, consumer always ready
    ready_a = 1'b1;
    pulses_a = 0; vcyc_a = 0; words_a = 0;
    hs_byte(8'hA5);
    cyc(3);
    check("a5_word", last_a, 8'hA5);
    check("a5_words", words_a, 1);
    check("a5_vcyc", vcyc_a, 1);
    check("a5_pulses", pulses_a, 8);
    check("a5_valid_low", wv_a, 0);

    // Backpressure: 0x11 held, 0x22 parked, first bit of 0x33 stalled
    ready_a = 1'b0;
    words_a = 0;
    hs_byte(8'h11);
    hs_byte(8'h22);
    check("bp_held", wd_a, 8'h11);
    check("bp_valid", wv_a, 1);
    check("bp_full", bc_a, 8);
    w33 = 8'h33;
    drive(0, 1'b1, w33[7]);
    cyc(20);
    check("bp_no_ack", ack_a, 0);
    check("bp_full2", bc_a, 8);
    ready_a = 1'b1;
    cyc(1);
    ready_a = 1'b0;
    check("bp_first", last_a, 8'h11);
    check("bp_moved", wd_a, 8'h22);
    wait_ack(0, 1'b1, 30, ok);
    check("bp_acked", 32'(ok), 1);
    drive(0, 1'b0, w33[7]);
    wait_ack(0, 1'b0, 30, ok);
    if (!ok) check("ack_fall_timeout", 32'd1, 32'd0);
    for (int i = 6; i >= 0; i--) hs_bit(0, w33[i]);
    check("bp_still22", wd_a, 8'h22);
    check("bp_full3", bc_a, 8);
    ready_a = 1'b1;
    cyc(4);
    check("bp_last33", last_a, 8'h33);
    check("bp_words", words_a, 3);
    check("bp_drained", wv_a, 0);
    check("bp_cnt0", bc_a, 0);

    // Long-held send counts one bit only
    p0 = pulses_a;
    drive(0, 1'b1, 1'b1);
    cyc(50);
    check("hold_ack", ack_a, 1);
    check("hold_cnt", bc_a, 1);
    check("hold_pulses", pulses_a - p0, 1);
    drive(0, 1'b0, 1'b1);
    wait_ack(0, 1'b0, 30, ok);
    check("hold_ack_fall", 32'(ok), 1);
    check("hold_cnt2", bc_a, 1);

    // clr drops partial bits
    hs_bit(0, 1'b0);
    hs_bit(0, 1'b1);
    check("clr_pre", bc_a, 3);
    clr_a = 1'b1;
    cyc(1);
    clr_a = 1'b0;
    check("clr_cnt", bc_a, 0);
    hs_byte(8'h3C);
    cyc(4);
    check("clr_word", last_a, 8'h3C);
    check("clr_cnt_end", bc_a, 0);

    // Reset in the middle of a handshake
    for (int i = 0; i < 5; i++) hs_bit(0, 1'b0);
    drive(0, 1'b1, 1'b0);
    wait_ack(0, 1'b1, 30, ok);
    check("mid_ack_hi", ack_a, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_ack", ack_a, 0);
    check("mid_rst_cnt", bc_a, 0);
    check("mid_rst_valid", wv_a, 0);
    drive(0, 1'b0, 1'b0);
    cyc(3);
    rst = 1'b1;
    cyc(2);
    words_a = 0;
    hs_byte(8'hFF);
    cyc(4);
    check("post_rst_word", last_a, 8'hFF);
    check("post_rst_words", words_a, 1);

    // 4-bit LSB-first: bits 1,1,0,0 -> 4'h3
    ready_b = 1'b1;
    hs_bit(1, 1'b1);
    hs_bit(1, 1'b1);
    hs_bit(1, 1'b0);
    hs_bit(1, 1'b0);
    cyc(4);
    check("lsb_word", last_b, 4'h3);
    check("lsb_words", words_b, 1);
    check("lsb_cnt", bc_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule : tb_hs_word_rx
